// File: rtl/obstacle_wave_if.sv
// Bundle between the game logic (master) and the obstacle wave controller (slave).
interface obstacle_wave_if #(
   parameter int SCORE_W = 8
);
   logic               tick;
   logic               start;
   logic               wave_done;
   logic               in_zone;
   logic [1:0]         car_lane;
   logic [3:0]         lane_en;
   logic [1:0]         lives;
   logic [SCORE_W-1:0] score;
   logic               hit;
   logic               invul;
   logic               game_over;

   modport master (
      output tick, start, wave_done, in_zone, car_lane,
      input  lane_en, lives, score, hit, invul, game_over
   );

   modport slave (
      input  tick, start, wave_done, in_zone, car_lane,
      output lane_en, lives, score, hit, invul, game_over
   );
endinterface

// File: rtl/obstacle_wave_ctrl.sv
// Obstacle wave controller: loads pseudo-random lane patterns on every wave
// wrap, detects car hits, and tracks lives, score and IDLE/RUN/HIT/OVER state.
module obstacle_wave_ctrl #(
   parameter int         LIVES       = 3,
   parameter int         SCORE_W     = 8,
   parameter int         INVUL_TICKS = 16,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic             clk,
   input  logic             reset,
   obstacle_wave_if.slave   bus
);

   localparam int CNT_W = $clog2(INVUL_TICKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_OVER} state_t;

   state_t             state_q, state_d;
   logic [7:0]         lfsr_q;
   logic               start_prev_q, wave_prev_q;
   logic [3:0]         lane_en_q, lane_en_d;
   logic [1:0]         lives_q, lives_d;
   logic [SCORE_W-1:0] score_q, score_d, score_sat;
   logic               hit_q, hit_d;
   logic               hit_this_wave_q, hit_this_wave_d;
   logic [CNT_W-1:0]   invul_cnt_q, invul_cnt_d;
   logic               start_rise, wave_rise, hit_cond;
   logic [3:0]         pattern;

   // Guarantees 1..3 lanes open: an all-closed or all-open draw is patched
   // at the lane chosen by bits [5:4].
   function automatic logic [3:0] pattern_of(input logic [7:0] s);
      logic [3:0] p;
      p = s[3:0];
      if (s[3:0] == 4'hF)      p[s[5:4]] = 1'b0;
      else if (s[3:0] == 4'h0) p[s[5:4]] = 1'b1;
      return p;
   endfunction

   assign start_rise = bus.start & ~start_prev_q;
   assign wave_rise  = bus.wave_done & ~wave_prev_q;
   assign pattern    = pattern_of(lfsr_q);
   assign hit_cond   = bus.in_zone & lane_en_q[bus.car_lane] & ~hit_this_wave_q;
   assign score_sat  = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

   // Free-running LFSR and input edge registers; never gated by game state.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr_q       <= LFSR_SEED;
         start_prev_q <= 1'b0;
         wave_prev_q  <= 1'b0;
      end else begin
         lfsr_q       <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
         start_prev_q <= bus.start;
         wave_prev_q  <= bus.wave_done;
      end
   end

   // Game state and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         lane_en_q       <= 4'h0;
         lives_q         <= 2'(LIVES);
         score_q         <= '0;
         hit_q           <= 1'b0;
         hit_this_wave_q <= 1'b0;
         invul_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         lane_en_q       <= lane_en_d;
         lives_q         <= lives_d;
         score_q         <= score_d;
         hit_q           <= hit_d;
         hit_this_wave_q <= hit_this_wave_d;
         invul_cnt_q     <= invul_cnt_d;
      end
   end

   // Next-state and next-output decode.
   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d         = state_q;
      lane_en_d       = lane_en_q;
      lives_d         = lives_q;
      score_d         = score_q;
      hit_d           = 1'b0;
      hit_this_wave_d = hit_this_wave_q;
      invul_cnt_d     = invul_cnt_q;

      case (state_q)
         S_IDLE: begin
            lane_en_d = 4'h0;
            if (start_rise) begin
               state_d         = S_RUN;
               lives_d         = 2'(LIVES);
               score_d         = '0;
               hit_this_wave_d = 1'b0;
               lane_en_d       = pattern;
            end
         end

         S_RUN: begin
            if (hit_cond) begin
               hit_d           = 1'b1;
               lives_d         = lives_q - 2'd1;
               hit_this_wave_d = 1'b1;
               if (lives_q == 2'd1) begin
                  // Last life: any simultaneous wave update is dropped.
                  state_d   = S_OVER;
                  lane_en_d = 4'h0;
               end else begin
                  state_d     = S_HIT;
                  invul_cnt_d = CNT_W'(INVUL_TICKS);
                  if (wave_rise) begin
                     hit_this_wave_d = 1'b0;
                     lane_en_d       = pattern;
                  end
               end
            end else if (wave_rise) begin
               if (!hit_this_wave_q) score_d = score_sat;
               hit_this_wave_d = 1'b0;
               lane_en_d       = pattern;
            end
         end

         S_HIT: begin
            if (bus.tick) begin
               if (invul_cnt_q <= CNT_W'(1)) begin
                  invul_cnt_d = '0;
                  state_d     = S_RUN;
               end else begin
                  invul_cnt_d = invul_cnt_q - CNT_W'(1);
               end
            end
            if (wave_rise) begin
               if (!hit_this_wave_q) score_d = score_sat;
               hit_this_wave_d = 1'b0;
               lane_en_d       = pattern;
            end
         end

         S_OVER: begin
            lane_en_d = 4'h0;
            if (start_rise) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.lane_en   = lane_en_q;
   assign bus.lives     = lives_q;
   assign bus.score     = score_q;
   assign bus.hit       = hit_q;
   assign bus.invul     = (state_q == S_HIT);
   assign bus.game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_obstacle_wave_ctrl.sv
// Self-checking bench for obstacle_wave_ctrl: an 8-bit-score instance runs the
// game flow, a 4-bit-score instance checks score saturation. Expected lane
// patterns come from a bench-side LFSR model and pass through a queue.
module tb_obstacle_wave_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [7:0] m_lfsr;
   logic [3:0] exp_q[$];
   logic [3:0] exp_lane;
   logic [3:0] cur_lanes;

   obstacle_wave_if #(.SCORE_W(8)) bus8 ();
   obstacle_wave_if #(.SCORE_W(4)) bus4 ();

   obstacle_wave_ctrl #(.LIVES(3), .SCORE_W(8), .INVUL_TICKS(16), .LFSR_SEED(8'hA5)) dut (
      .clk(clk), .reset(reset), .bus(bus8.slave)
   );

   obstacle_wave_ctrl #(.LIVES(3), .SCORE_W(4), .INVUL_TICKS(16), .LFSR_SEED(8'hA5)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, shifted left each clock.
   always @(posedge clk) begin
      if (!reset) m_lfsr <= 8'hA5;
      else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [3:0] model_pattern(input logic [7:0] s);
      logic [3:0] p;
      int k;
      p = s[3:0];
      k = int'(s[5:4]);
      if (p == 4'b1111)      p[k] = 1'b0;
      else if (p == 4'b0000) p[k] = 1'b1;
      return p;
   endfunction

   function automatic logic [1:0] lowest_lane(input logic [3:0] l);
      for (int i = 3; i >= 0; i--) if (l[i]) lowest_lane = 2'(i);
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic pop_exp();
      exp_lane = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) cyc();
      reset = 1'b1;
      repeat (10) cyc();
      checks++; if (bus8.lane_en !== 4'h0) begin errors++; $display("FAIL reset_lane_en: got %h expected 0", bus8.lane_en); end
      checks++; if (bus8.lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", bus8.lives); end
      checks++; if (bus8.score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", bus8.score); end
      checks++; if (bus8.game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", bus8.game_over); end
      checks++; if (bus8.hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", bus8.hit); end
      checks++; if (bus8.invul !== 1'b0) begin errors++; $display("FAIL reset_invul: got %b expected 0", bus8.invul); end
   endtask

   task automatic test_start();
      bus8.start = 1'b1;
      exp_q.push_back(model_pattern(m_lfsr));
      cyc();
      bus8.start = 1'b0;
      pop_exp();
      cur_lanes = exp_lane;
      checks++; if (bus8.lane_en !== exp_lane) begin errors++; $display("FAIL start_pattern: got %h expected %h", bus8.lane_en, exp_lane); end
      checks++; if ($countones(bus8.lane_en) < 1 || $countones(bus8.lane_en) > 3) begin errors++; $display("FAIL start_lane_count: got %0d lanes expected 1..3", $countones(bus8.lane_en)); end
      checks++; if (bus8.lives !== 2'd3 || bus8.score !== 8'd0) begin errors++; $display("FAIL start_lives_score: got lives=%0d score=%0d expected 3/0", bus8.lives, bus8.score); end
   endtask

   task automatic test_wave_hold();
      int changes;
      changes = 0;
      bus8.wave_done = 1'b1;
      exp_q.push_back(model_pattern(m_lfsr));
      cyc();
      pop_exp();
      cur_lanes = exp_lane;
      checks++; if (bus8.lane_en !== exp_lane) begin errors++; $display("FAIL wave_pattern: got %h expected %h", bus8.lane_en, exp_lane); end
      for (int i = 0; i < 49; i++) begin
         cyc();
         if (bus8.lane_en !== cur_lanes || bus8.score !== 8'd1) changes++;
      end
      bus8.wave_done = 1'b0;
      cyc();
      checks++; if (changes !== 0) begin errors++; $display("FAIL wave_hold_changes: got %0d extra changes expected 0", changes); end
      checks++; if (bus8.score !== 8'd1) begin errors++; $display("FAIL wave_score: got %0d expected 1", bus8.score); end
   endtask

   task automatic wait_invul(input string tag);
      for (int i = 1; i <= 16; i++) begin
         bus8.tick = 1'b1;
         cyc();
         bus8.tick = 1'b0;
         cyc();
         if (i == 15) begin
            checks++; if (bus8.invul !== 1'b1) begin errors++; $display("FAIL %s_invul_15: got %b expected 1", tag, bus8.invul); end
         end
      end
      checks++; if (bus8.invul !== 1'b0) begin errors++; $display("FAIL %s_invul_end: got %b expected 0", tag, bus8.invul); end
   endtask

   task automatic test_hit();
      int pulses;
      pulses = 0;
      bus8.car_lane = lowest_lane(cur_lanes);
      bus8.in_zone = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (bus8.hit === 1'b1) pulses++;
         if (i == 0) begin
            checks++; if (bus8.hit !== 1'b1 || bus8.lives !== 2'd2 || bus8.invul !== 1'b1) begin
               errors++; $display("FAIL hit_first: got hit=%b lives=%0d invul=%b expected 1/2/1", bus8.hit, bus8.lives, bus8.invul);
            end
         end
      end
      bus8.in_zone = 1'b0;
      checks++; if (pulses !== 1) begin errors++; $display("FAIL hit_pulses: got %0d expected 1", pulses); end
      wait_invul("hit");
      bus8.wave_done = 1'b1;
      exp_q.push_back(model_pattern(m_lfsr));
      cyc();
      bus8.wave_done = 1'b0;
      pop_exp();
      cur_lanes = exp_lane;
      checks++; if (bus8.score !== 8'd1) begin errors++; $display("FAIL hit_wave_score: got %0d expected 1", bus8.score); end
      checks++; if (bus8.lane_en !== exp_lane) begin errors++; $display("FAIL hit_wave_pattern: got %h expected %h", bus8.lane_en, exp_lane); end
      cyc();
   endtask

   task automatic test_hit_and_wave();
      bus8.car_lane = lowest_lane(cur_lanes);
      bus8.in_zone = 1'b1;
      bus8.wave_done = 1'b1;
      exp_q.push_back(model_pattern(m_lfsr));
      cyc();
      bus8.in_zone = 1'b0;
      bus8.wave_done = 1'b0;
      pop_exp();
      cur_lanes = exp_lane;
      checks++; if (bus8.hit !== 1'b1 || bus8.lives !== 2'd1) begin errors++; $display("FAIL simul_hit: got hit=%b lives=%0d expected 1/1", bus8.hit, bus8.lives); end
      checks++; if (bus8.score !== 8'd1) begin errors++; $display("FAIL simul_score: got %0d expected 1", bus8.score); end
      checks++; if (bus8.lane_en !== exp_lane) begin errors++; $display("FAIL simul_pattern: got %h expected %h", bus8.lane_en, exp_lane); end
      wait_invul("simul");
      // The hit wave was already closed, so this wave is a clean one.
      bus8.wave_done = 1'b1;
      exp_q.push_back(model_pattern(m_lfsr));
      cyc();
      bus8.wave_done = 1'b0;
      pop_exp();
      cur_lanes = exp_lane;
      checks++; if (bus8.score !== 8'd2) begin errors++; $display("FAIL simul_next_score: got %0d expected 2", bus8.score); end
      cyc();
   endtask

   task automatic test_game_over();
      bus8.car_lane = lowest_lane(cur_lanes);
      bus8.in_zone = 1'b1;
      cyc();
      bus8.in_zone = 1'b0;
      checks++; if (bus8.hit !== 1'b1 || bus8.lives !== 2'd0 || bus8.game_over !== 1'b1) begin
         errors++; $display("FAIL over_entry: got hit=%b lives=%0d game_over=%b expected 1/0/1", bus8.hit, bus8.lives, bus8.game_over);
      end
      checks++; if (bus8.lane_en !== 4'h0) begin errors++; $display("FAIL over_lane_en: got %h expected 0", bus8.lane_en); end
      for (int i = 0; i < 3; i++) begin
         bus8.wave_done = 1'b1;
         cyc();
         bus8.wave_done = 1'b0;
         cyc();
      end
      checks++; if (bus8.score !== 8'd2 || bus8.lane_en !== 4'h0) begin errors++; $display("FAIL over_waves: got score=%0d lane_en=%h expected 2/0", bus8.score, bus8.lane_en); end
      bus8.start = 1'b1;
      cyc();
      bus8.start = 1'b0;
      checks++; if (bus8.game_over !== 1'b0 || bus8.lane_en !== 4'h0 || bus8.score !== 8'd2) begin
         errors++; $display("FAIL over_to_idle: got game_over=%b lane_en=%h score=%0d expected 0/0/2", bus8.game_over, bus8.lane_en, bus8.score);
      end
      cyc();
      bus8.start = 1'b1;
      exp_q.push_back(model_pattern(m_lfsr));
      cyc();
      bus8.start = 1'b0;
      pop_exp();
      cur_lanes = exp_lane;
      checks++; if (bus8.lives !== 2'd3 || bus8.score !== 8'd0 || bus8.lane_en !== exp_lane) begin
         errors++; $display("FAIL restart: got lives=%0d score=%0d lane_en=%h expected 3/0/%h", bus8.lives, bus8.score, bus8.lane_en, exp_lane);
      end
   endtask

   task automatic test_saturation();
      logic [3:0] exp_score;
      bus4.start = 1'b1;
      exp_q.push_back(model_pattern(m_lfsr));
      cyc();
      bus4.start = 1'b0;
      pop_exp();
      checks++; if (bus4.lane_en !== exp_lane) begin errors++; $display("FAIL sat_start_pattern: got %h expected %h", bus4.lane_en, exp_lane); end
      exp_score = 4'd0;
      for (int n = 1; n <= 20; n++) begin
         bus4.wave_done = 1'b1;
         exp_q.push_back(model_pattern(m_lfsr));
         cyc();
         bus4.wave_done = 1'b0;
         pop_exp();
         if (exp_score != 4'hF) exp_score = exp_score + 4'd1;
         checks++; if (bus4.score !== exp_score || bus4.lane_en !== exp_lane) begin
            errors++; $display("FAIL sat_wave_%0d: got score=%0d lane_en=%h expected %0d/%h", n, bus4.score, bus4.lane_en, exp_score, exp_lane);
         end
         cyc();
      end
      checks++; if (bus4.score !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d expected 15", bus4.score); end
   endtask

   task automatic test_reset_mid_run();
      bus8.tick = 1'b1;
      reset = 1'b0;
      cyc();
      bus8.tick = 1'b0;
      checks++; if (bus8.lane_en !== 4'h0 || bus8.lives !== 2'd3 || bus8.score !== 8'd0) begin
         errors++; $display("FAIL midreset_regs: got lane_en=%h lives=%0d score=%0d expected 0/3/0", bus8.lane_en, bus8.lives, bus8.score);
      end
      checks++; if (bus8.hit !== 1'b0 || bus8.invul !== 1'b0 || bus8.game_over !== 1'b0) begin
         errors++; $display("FAIL midreset_flags: got hit=%b invul=%b game_over=%b expected 0/0/0", bus8.hit, bus8.invul, bus8.game_over);
      end
      checks++; if (bus4.score !== 4'd0 || bus4.lane_en !== 4'h0) begin
         errors++; $display("FAIL midreset_dut4: got score=%0d lane_en=%h expected 0/0", bus4.score, bus4.lane_en);
      end
      reset = 1'b1;
      cyc();
   endtask

   initial begin
      bus8.tick = 1'b0; bus8.start = 1'b0; bus8.wave_done = 1'b0; bus8.in_zone = 1'b0; bus8.car_lane = 2'd0;
      bus4.tick = 1'b0; bus4.start = 1'b0; bus4.wave_done = 1'b0; bus4.in_zone = 1'b0; bus4.car_lane = 2'd0;
      cur_lanes = 4'h0;
      cyc();
      test_reset();
      test_start();
      test_wave_hold();
      test_hit();
      test_hit_and_wave();
      test_game_over();
      test_saturation();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/obstacle_wave_ctrl.md
Name: obstacle_wave_ctrl

Overview:
Game-side controller that drives the four lane-enable inputs of the falling-obstacle renderer and consumes its wrap strobe and in-zone flag. On each obstacle-wave wrap it loads a new pseudo-random lane pattern. It also detects car/obstacle hits, manages lives and score, and runs the IDLE/RUN/HIT/OVER game state machine. It sits between the input/car logic and the obstacle renderer.

Parameters:
LIVES, 3, starting lives (1..3)
SCORE_W, 8, score counter width
INVUL_TICKS, 16, tick pulses of invulnerability after a hit
LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low
tick  in  1  one-cycle game-step enable (renderer step rate)
start  in  1  start button, level; rising edge used
wave_done  in  1  renderer wrap flag, level; rising edge = wave finished
in_zone  in  1  renderer obstacle Y overlaps car row
car_lane  in  2  car lane index 0..3
lane_en  out  4  obstacle lane enables to renderer (bit i = lane i)
lives  out  2  remaining lives
score  out  SCORE_W  waves survived
hit  out  1  one-cycle pulse on registered hit
invul  out  1  high in HIT state
game_over  out  1  high in OVER state

Behaviour:
- Clock is clk; reset is synchronous, active-low. Reset overrides everything, including mid-game: state=IDLE, lane_en=0, lives=LIVES, score=0, hit=0, invul=0, game_over=0, lfsr=LFSR_SEED, edge registers=0, hit_this_wave=0, invul_cnt=0.
- Edge detect: start_prev and wave_prev are registered each cycle. start_rise=start&~start_prev; wave_rise=wave_done&~wave_prev.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts left every clk, new bit0 = b7^b5^b4^b3. Free-running in all states.
- Pattern function from current lfsr: p=lfsr[3:0], k=lfsr[5:4].
  - If p==4'b1111, clear bit k.
  - If p==4'b0000, set bit k.
  - Otherwise use p as is.
  - Result always has 1..3 lanes enabled.
- IDLE: lane_en=0. On start_rise go to RUN; lives=LIVES, score=0, hit_this_wave=0, lane_en=pattern (all loaded on the same edge).
- RUN:
  - Hit condition: in_zone & lane_en[car_lane] & ~hit_this_wave.
  - On hit: hit pulses high for 1 cycle (registered), hit_this_wave=1, lives-=1.
  - If lives was 1, go to OVER with lane_en=0. Otherwise go to HIT with invul_cnt=INVUL_TICKS.
- HIT: invul=1, no hit detection. invul_cnt decrements on each tick; when it reaches 0 (at that tick edge) return to RUN.
- Wave handling (RUN and HIT) on wave_rise:
  - If hit_this_wave==0, score+=1, saturating at all-ones.
  - hit_this_wave cleared.
  - lane_en=pattern.
- Simultaneous hit and wave_rise in RUN: the hit counts, score is not incremented, new pattern is loaded, hit_this_wave ends at 0. A hit that drives lives to 0 goes to OVER; the wave update is discarded and lane_en=0.
- OVER: game_over=1, lane_en=0, score and lives held (lives=0). On start_rise go to IDLE (score held until next RUN entry).
- wave_done held high for many cycles counts once. in_zone held high counts at most one hit per wave.
- Latency: every output is registered and changes 1 clk after the sampled cause.

Test Plan:
- Reset, then idle 10 cycles -> lane_en=0, lives=3, score=0, game_over=0, hit=0.
- start rising edge -> next cycle in RUN, lane_en equals the pattern of the lfsr value at that edge (bench model), has 1..3 bits set. wave_done held high 50 cycles -> exactly one pattern change, score=1.
- car_lane=i with lane_en[i]=1, in_zone=1 for 20 cycles -> single hit pulse, lives=2, invul=1. After 16 tick pulses -> invul=0. Next wave_rise -> score unchanged for the hit wave.
- Three hits on separate waves -> lives 3→2→1→0, game_over=1, lane_en=0. Further wave_done edges leave score unchanged. start edge -> IDLE.
- SCORE_W=4, 20 clean waves -> score saturates at 15.
- Hit and wave_rise on the same cycle with lives=2 -> lives=1, score unchanged, new pattern loaded. Reset asserted mid-RUN -> all outputs at reset values on the next cycle.
